// File: rtl/fighter_pkg.sv
// -----------------------------------------------------------------------------
// fighter_pkg
// Shared definitions for the fighter motion block: FSM state encoding,
// character_state output codes, screen geometry and a horizontal clamp helper.
// -----------------------------------------------------------------------------
package fighter_pkg;

  // Playfield geometry in pixels.
  localparam int SCREEN_W = 96;
  localparam int SCREEN_H = 64;

  // Datapath widths: 7-bit positions cover the 96x64 screen, vertical speed
  // is a signed 6-bit value.
  localparam int POS_W = 7;
  localparam int VY_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_AIR    = 2'd2,
    ST_ATTACK = 2'd3
  } state_e;

  // character_state codes; 2'b10 and 2'b11 are reserved.
  localparam logic [1:0] CS_IDLE  = 2'b00;
  localparam logic [1:0] CS_PUNCH = 2'b01;

  // One horizontal step left or right, held inside [lo, hi].
  function automatic logic [POS_W-1:0] clamp_step(
    input logic [POS_W-1:0] pos,
    input logic             left,
    input int               step,
    input int               lo,
    input int               hi
  );
    int p;
    p = int'(pos);
    if (left) p = p - step;
    else      p = p + step;
    if (p < lo) p = lo;
    if (p > hi) p = hi;
    return POS_W'(p);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Rising-edge detector for a debounced level input. The previous-sample
// register updates on every clock cycle, so rise is a one-cycle pulse in the
// first cycle the input is seen high.
//   clk  : system clock
//   rst  : synchronous, active-high reset (clears the sample register)
//   in   : debounced level input
//   rise : high while in=1 and the previous-cycle sample was 0
// -----------------------------------------------------------------------------
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= in;
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/fighter_motion.sv
// -----------------------------------------------------------------------------
// fighter_motion
// Frame-rate movement controller for one fighter sprite: walking with wall
// clamping, a ballistic jump, and a fixed-length attack. Every game update
// happens on a clk edge where frame_tick=1; all outputs are registered.
//   clk             : system clock
//   rst             : synchronous, active-high reset (beats frame_tick)
//   frame_tick      : one-cycle pulse marking a game frame
//   btn_left/right  : debounced walk inputs
//   btn_up          : debounced jump input (level)
//   btn_attack      : debounced attack input (rising edge starts an attack)
//   x, y            : sprite centre position in pixels
//   in_air          : sprite is airborne
//   is_moving       : exactly one direction held and motion is allowed
//   mirror          : 1 = sprite faces left
//   character_state : CS_IDLE or CS_PUNCH
// -----------------------------------------------------------------------------
module fighter_motion
  import fighter_pkg::*;
#(
  parameter int START_X       = 24,
  parameter bit START_MIRROR  = 1'b0,
  parameter int X_MIN         = 16,
  parameter int X_MAX         = 80,
  parameter int Y_GROUND      = 32,
  parameter int WALK_STEP     = 1,
  parameter int JUMP_V        = 6,
  parameter int GRAVITY       = 1,
  parameter int ATTACK_FRAMES = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_up,
  input  logic             btn_attack,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y,
  output logic             in_air,
  output logic             is_moving,
  output logic             mirror,
  output logic [1:0]       character_state
);

  localparam int CNT_W = (ATTACK_FRAMES > 2) ? $clog2(ATTACK_FRAMES) : 1;

  localparam logic [POS_W-1:0]       X_RST    = POS_W'(START_X);
  localparam logic [POS_W-1:0]       Y_GND    = POS_W'(Y_GROUND);
  localparam logic [POS_W-1:0]       Y_JUMP   = POS_W'(Y_GROUND - JUMP_V);
  localparam logic signed [VY_W-1:0] VY_LAUNCH = VY_W'(GRAVITY - JUMP_V);
  localparam logic signed [VY_W-1:0] VY_GRAV   = VY_W'(GRAVITY);
  localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(ATTACK_FRAMES - 1);
  localparam logic signed [POS_W+1:0] Y_GND_S  = (POS_W+2)'(Y_GROUND);

  state_e                   state_q, state_d;
  logic [POS_W-1:0]         x_q, x_d;
  logic [POS_W-1:0]         y_q, y_d;
  logic signed [VY_W-1:0]   vy_q, vy_d;
  logic                     in_air_q, in_air_d;
  logic                     is_moving_q, is_moving_d;
  logic                     mirror_q, mirror_d;
  logic [1:0]               cs_q, cs_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     atk_rise;
  logic                     one_dir;
  logic [POS_W-1:0]         x_walk;
  logic signed [POS_W+1:0]  y_sum;

  btn_edge u_atk_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (btn_attack),
    .rise (atk_rise)
  );

  // Holding both directions cancels out: no motion, no facing change.
  assign one_dir = btn_left ^ btn_right;
  assign x_walk  = clamp_step(x_q, btn_left, WALK_STEP, X_MIN, X_MAX);

  // Airborne height update in a widened signed domain so a negative or
  // past-ground result can be detected before it is clamped.
  assign y_sum = $signed({2'b00, y_q}) + $signed({{3{vy_q[VY_W-1]}}, vy_q});

  // NOTE: every signal written here gets its hold value first, so no path
  // through the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    in_air_d    = in_air_q;
    is_moving_d = is_moving_q;
    mirror_d    = mirror_q;
    cs_d        = cs_q;
    cnt_d       = cnt_q;

    if (frame_tick) begin
      unique case (state_q)
        ST_IDLE, ST_WALK: begin
          if (atk_rise) begin
            state_d     = ST_ATTACK;
            cs_d        = CS_PUNCH;
            cnt_d       = CNT_LOAD;
            is_moving_d = 1'b0;
          end else begin
            is_moving_d = one_dir;
            if (btn_up) begin
              state_d  = ST_AIR;
              in_air_d = 1'b1;
              y_d      = Y_JUMP;
              vy_d     = VY_LAUNCH;
            end else if (one_dir) begin
              state_d = ST_WALK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_AIR: begin
          // Attack edges and btn_up are ignored until the sprite lands.
          is_moving_d = one_dir;
          if (y_sum >= Y_GND_S) begin
            state_d  = ST_IDLE;
            y_d      = Y_GND;
            vy_d     = '0;
            in_air_d = 1'b0;
          end else begin
            y_d  = (y_sum < 0) ? '0 : y_sum[POS_W-1:0];
            vy_d = vy_q + VY_GRAV;
          end
        end

        ST_ATTACK: begin
          // Movement, jump and further attack edges are ignored; the exit
          // tick itself is still part of the attack, so nothing moves on it.
          is_moving_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            cs_d    = CS_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      endcase

      // is_moving_d is only raised where motion is allowed, so it doubles
      // as the step enable; a clamped step still updates the facing.
      if (is_moving_d) begin
        x_d      = x_walk;
        mirror_d = btn_left;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= X_RST;
      y_q         <= Y_GND;
      vy_q        <= '0;
      in_air_q    <= 1'b0;
      is_moving_q <= 1'b0;
      mirror_q    <= START_MIRROR;
      cs_q        <= CS_IDLE;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      in_air_q    <= in_air_d;
      is_moving_q <= is_moving_d;
      mirror_q    <= mirror_d;
      cs_q        <= cs_d;
      cnt_q       <= cnt_d;
    end
  end

  assign x               = x_q;
  assign y               = y_q;
  assign in_air          = in_air_q;
  assign is_moving       = is_moving_q;
  assign mirror          = mirror_q;
  assign character_state = cs_q;

endmodule

// File: tb/tb_fighter_motion.sv
// -----------------------------------------------------------------------------
// tb_fighter_motion
// Drives fighter_motion cycle by cycle. Each driven cycle advances a
// behavioural model of the game rules and queues the outputs expected after
// that clock edge; an independent monitor pops and compares after every edge.
// Directed scenarios also spot-check known constant results.
// -----------------------------------------------------------------------------
module tb_fighter_motion;

  localparam int P_START_X = 24;
  localparam int P_X_MIN   = 16;
  localparam int P_X_MAX   = 80;
  localparam int P_Y_GND   = 32;
  localparam int P_STEP    = 1;
  localparam int P_JUMP_V  = 6;
  localparam int P_GRAV    = 1;
  localparam int P_ATK     = 12;

  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
    logic       in_air;
    logic       is_moving;
    logic       mirror;
    logic [1:0] cs;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_attack = 1'b0;
  logic [6:0] x, y;
  logic       in_air, is_moving, mirror;
  logic [1:0] character_state;

  int n_checks = 0;
  int n_fail   = 0;

  obs_t exp_q[$];

  // Reference model state: the attack is tracked as frames of CS_PUNCH left.
  int m_x, m_y, m_vy, m_atk_left;
  bit m_air, m_mov, m_mir, m_prev_atk;

  fighter_motion dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .btn_up          (btn_up),
    .btn_attack      (btn_attack),
    .x               (x),
    .y               (y),
    .in_air          (in_air),
    .is_moving       (is_moving),
    .mirror          (mirror),
    .character_state (character_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_walk(input bit l, input bit one);
    m_mov = one;
    if (one) begin
      if (l) begin
        m_x   = (m_x - P_STEP < P_X_MIN) ? P_X_MIN : m_x - P_STEP;
        m_mir = 1'b1;
      end else begin
        m_x   = (m_x + P_STEP > P_X_MAX) ? P_X_MAX : m_x + P_STEP;
        m_mir = 1'b0;
      end
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit l, input bit rt,
                            input bit u, input bit a);
    bit rise, one;
    int ny;
    if (r) begin
      m_x = P_START_X; m_y = P_Y_GND; m_vy = 0; m_atk_left = 0;
      m_air = 0; m_mov = 0; m_mir = 0; m_prev_atk = 0;
      return;
    end
    if (t) begin
      rise = a && !m_prev_atk;
      one  = (l != rt);
      if (m_atk_left > 0) begin
        m_atk_left--;
        m_mov = 0;
      end else if (m_air) begin
        model_walk(l, one);
        ny = m_y + m_vy;
        if (ny >= P_Y_GND) begin
          m_y = P_Y_GND; m_vy = 0; m_air = 0;
        end else begin
          m_y  = (ny < 0) ? 0 : ny;
          m_vy = m_vy + P_GRAV;
        end
      end else if (rise) begin
        m_atk_left = P_ATK;
        m_mov      = 0;
      end else begin
        model_walk(l, one);
        if (u) begin
          m_air = 1; m_y = P_Y_GND - P_JUMP_V; m_vy = P_GRAV - P_JUMP_V;
        end
      end
    end
    m_prev_atk = a;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.x = 7'(m_x); o.y = 7'(m_y); o.in_air = m_air; o.is_moving = m_mov;
    o.mirror = m_mir; o.cs = (m_atk_left > 0) ? 2'b01 : 2'b00;
    return o;
  endfunction

  // One clock cycle: drive at the falling edge, queue the expectation,
  // return shortly after the rising edge once the monitor has compared.
  task automatic cyc(input bit r, input bit t, input bit l, input bit rt,
                     input bit u, input bit a);
    @(negedge clk);
    rst = r; frame_tick = t;
    btn_left = l; btn_right = rt; btn_up = u; btn_attack = a;
    model_step(r, t, l, rt, u, a);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #2;
  endtask

  // One frame tick followed by a few idle cycles with the buttons held.
  task automatic tick(input bit l, input bit rt, input bit u, input bit a);
    int gap;
    cyc(1'b0, 1'b1, l, rt, u, a);
    gap = $urandom_range(0, 2);
    repeat (gap) cyc(1'b0, 1'b0, l, rt, u, a);
  endtask

  // Monitor: every edge that has a queued expectation is compared.
  always @(posedge clk) begin
    obs_t got, want;
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = '{x: x, y: y, in_air: in_air, is_moving: is_moving,
               mirror: mirror, cs: character_state};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL outputs @%0t: got x=%0d y=%0d air=%0b mov=%0b mir=%0b cs=%0d, expected x=%0d y=%0d air=%0b mov=%0b mir=%0b cs=%0d",
                 $time, got.x, got.y, got.in_air, got.is_moving, got.mirror, got.cs,
                 want.x, want.y, want.in_air, want.is_moving, want.mirror, want.cs);
      end
    end
  end

  int jump_y[13] = '{26, 21, 17, 14, 12, 11, 11, 12, 14, 17, 21, 26, 32};

  initial begin
    int cs_count;
    bit l, rt, u, a, r, t;

    // Reset state.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 1);
    check("reset_x", x, 24);
    check("reset_y", y, 32);
    check("reset_cs", character_state, 0);
    check("reset_air", in_air, 0);
    check("reset_mirror", mirror, 0);

    // Walk right 10 ticks, then release.
    repeat (10) tick(0, 1, 0, 0);
    check("walk_right_x", x, 34);
    check("walk_right_mirror", mirror, 0);
    check("walk_right_moving", is_moving, 1);
    tick(0, 0, 0, 0);
    check("release_moving", is_moving, 0);

    // Both directions: no motion, facing kept.
    tick(1, 1, 0, 0);
    check("both_dirs_x", x, 34);
    check("both_dirs_moving", is_moving, 0);

    // Walk left to x=20, then 8 more ticks into the wall.
    repeat (14) tick(1, 0, 0, 0);
    check("walk_left_x20", x, 20);
    repeat (8) tick(1, 0, 0, 0);
    check("wall_x", x, 16);
    check("wall_moving", is_moving, 1);
    check("wall_mirror", mirror, 1);
    tick(0, 0, 0, 0);

    // Jump arc from a single btn_up pulse.
    for (int i = 0; i < 13; i++) begin
      tick(0, 0, (i == 0), 0);
      check($sformatf("jump_y_t%0d", i + 1), y, jump_y[i]);
      check($sformatf("jump_air_t%0d", i + 1), in_air, (i < 12) ? 1 : 0);
    end

    // Attack with btn_up on the same tick; second edge at tick 5 ignored.
    cs_count = 0;
    for (int k = 1; k <= 14; k++) begin
      tick(0, 0, (k == 1), (k <= 2) || (k == 5));
      check($sformatf("atk_cs_k%0d", k), character_state, (k <= 12) ? 1 : 0);
      check($sformatf("atk_y_k%0d", k), y, 32);
      if (character_state == 2'b01) cs_count++;
    end
    check("atk_len", cs_count, 12);

    // Held attack: exactly one attack until release and re-press.
    cs_count = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(0, 0, 0, 1);
      if (character_state == 2'b01) cs_count++;
    end
    check("held_atk_len", cs_count, 12);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    check("repress_cs", character_state, 1);
    repeat (12) tick(0, 0, 0, 0);
    check("repress_end_cs", character_state, 0);

    // Reset during a jump, then a long stretch without frame ticks.
    repeat (3) tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 1);
    check("midjump_rst_y", y, 32);
    check("midjump_rst_air", in_air, 0);
    check("midjump_rst_x", x, 24);
    check("midjump_rst_cs", character_state, 0);
    repeat (100) cyc(0, 0, 1, 0, 1, 1);
    check("no_tick_x", x, 24);
    check("no_tick_y", y, 32);
    check("no_tick_moving", is_moving, 0);
    check("no_tick_cs", character_state, 0);

    // Randomised play against the model.
    l = 0; rt = 0; u = 0; a = 0;
    repeat (3000) begin
      if ($urandom_range(0, 4) == 0) l  = ~l;
      if ($urandom_range(0, 4) == 0) rt = ~rt;
      if ($urandom_range(0, 6) == 0) u  = ~u;
      if ($urandom_range(0, 3) == 0) a  = ~a;
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 2) == 0);
      cyc(r, t, l, rt, u, a);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
